// File: rtl/s5378_n514_scan_ctrl.sv
// Scan driver/capture stage for the s5378 n514 cone: serial load of the 29
// pseudo-primary inputs, settle, capture n514, then serial unload of {state, n514}.
module s5378_n514_scan_ctrl #(
    parameter int N_PI       = 29,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            scan_in,
    input  logic            n514,
    output logic [N_PI-1:0] cone_in,
    output logic            scan_out,
    output logic            cap_q,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE, SHIFT_IN, SETTLE, CAPTURE, SHIFT_OUT, DONE_S
    } state_t;

    // Terminal counts: cnt holds the number of cycles already spent in the state.
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(N_PI - 1);
    localparam logic [CNT_W-1:0] SET_LAST = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(N_PI);

    state_t            state, state_nx;
    logic [N_PI-1:0]   sr;
    logic [N_PI:0]     out_sr;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = SHIFT_IN;
            end
            SHIFT_IN:  if (cnt == IN_LAST)  state_nx = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
            SETTLE:    if (cnt == SET_LAST) state_nx = CAPTURE;
            CAPTURE:   state_nx = SHIFT_OUT;
            SHIFT_OUT: if (cnt == OUT_LAST) state_nx = DONE_S;
            DONE_S: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            out_sr <= '0;
            cnt    <= '0;
            cap_q  <= 1'b0;
        end else begin
            state <= state_nx;
            // Counter restarts on every state change so no state can run it past N_PI+1.
            if (state_nx != state)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;

            unique case (state)
                SHIFT_IN:  sr <= {scan_in, sr[N_PI-1:1]};
                CAPTURE: begin
                    cap_q  <= n514;
                    out_sr <= {sr, n514};
                end
                SHIFT_OUT: out_sr <= {1'b0, out_sr[N_PI:1]};
                default: ;
            endcase
        end
    end

    assign cone_in  = sr;
    assign scan_out = out_sr[0];

endmodule

// File: tb/tb_s5378_n514_scan_ctrl.sv
// Randomized self-checking bench: default build (A) and SETTLE_CYC=0 build (B)
// run side by side against a run-level reference model.
module tb_s5378_n514_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, scan_in, n514;
    logic [28:0] cone_a, cone_b;
    logic        so_a, so_b, cq_a, cq_b, busy_a, busy_b, done_a, done_b;

    int compared   = 0;
    int mismatched = 0;

    logic [28:0] prev_cone;
    logic        prev_cap_a, prev_cap_b;

    always #5 clk = ~clk;

    s5378_n514_scan_ctrl #(.N_PI(29), .SETTLE_CYC(2), .CNT_W(6)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .scan_in(scan_in), .n514(n514),
        .cone_in(cone_a), .scan_out(so_a), .cap_q(cq_a), .busy(busy_a), .done(done_a));

    s5378_n514_scan_ctrl #(.N_PI(29), .SETTLE_CYC(0), .CNT_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .scan_in(scan_in), .n514(n514),
        .cone_in(cone_b), .scan_out(so_b), .cap_q(cq_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input int k);
        chk("rst_busy_a", k, 32'(busy_a), 0);  chk("rst_busy_b", k, 32'(busy_b), 0);
        chk("rst_done_a", k, 32'(done_a), 0);  chk("rst_done_b", k, 32'(done_b), 0);
        chk("rst_cone_a", k, 32'(cone_a), 0);  chk("rst_cone_b", k, 32'(cone_b), 0);
        chk("rst_so_a",   k, 32'(so_a), 0);    chk("rst_so_b",   k, 32'(so_b), 0);
        chk("rst_cap_a",  k, 32'(cq_a), 0);    chk("rst_cap_b",  k, 32'(cq_b), 0);
    endtask

    // Expected outputs after edge k of a run. C = capture edge, D = DONE-entry edge.
    task automatic chk_dut(input string nm, input int k, input int c, input logic [28:0] w,
                           input logic [28:0] old, input logic capv, input logic capold,
                           input logic b, input logic d, input logic so, input logic cq,
                           input logic [28:0] ci);
        int          dd;
        logic [28:0] exp_ci;
        logic        exp_so;
        dd = c + 30;
        if (k == 0)      exp_ci = old;
        else if (k < 29) exp_ci = (old >> k) | (w << (29 - k));
        else             exp_ci = w;
        if (k == c)                   exp_so = capv;
        else if (k > c && k < c + 30) exp_so = w[k - c - 1];
        else                          exp_so = 1'b0;
        chk({"busy_", nm}, k, 32'(b), 32'(k <= dd));
        chk({"done_", nm}, k, 32'(d), 32'(k == dd));
        chk({"cone_", nm}, k, 32'(ci), 32'(exp_ci));
        chk({"sout_", nm}, k, 32'(so), 32'(exp_so));
        chk({"capq_", nm}, k, 32'(cq), 32'((k >= c) ? capv : capold));
    endtask

    // mode: 0 = n514 tied 1, 1 = n514 toggles (0 on even edges), 2 = random
    task automatic run(input logic [28:0] w, input int mode, input bit extra);
        logic        nh [0:66];
        logic [28:0] old;
        old = prev_cone;
        for (int k = 0; k <= 66; k++) begin
            start_a = (k == 0) || (extra && k >= 1 && k <= 63 &&
                                   (k == 10 || k == 63 || $urandom_range(1) == 1));
            start_b = (k == 0) || (extra && k >= 1 && k <= 61 &&
                                   (k == 10 || k == 61 || $urandom_range(1) == 1));
            scan_in = (k >= 1 && k <= 29) ? w[k-1] : 1'($urandom);
            n514    = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : 1'($urandom);
            nh[k]   = n514;
            @(posedge clk); #1;
            chk_dut("a", k, 32, w, old, nh[32 < k ? 32 : k], prev_cap_a,
                    busy_a, done_a, so_a, cq_a, cone_a);
            chk_dut("b", k, 30, w, old, nh[30 < k ? 30 : k], prev_cap_b,
                    busy_b, done_b, so_b, cq_b, cone_b);
        end
        start_a    = 1'b0;
        start_b    = 1'b0;
        prev_cone  = w;
        prev_cap_a = nh[32];
        prev_cap_b = nh[30];
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; scan_in = 1'b0; n514 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero(0);
        rst = 1'b0;
        prev_cone = '0; prev_cap_a = 1'b0; prev_cap_b = 1'b0;

        // Load alternating pattern with random n514.
        run(29'h1555_5555, 2, 1'b0);

        // Reset in the middle of SHIFT_IN aborts both runs.
        start_a = 1'b1; start_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            scan_in = 1'($urandom);
        end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk_idle_zero(k);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_zero(4);
        prev_cone = '0; prev_cap_a = 1'b0; prev_cap_b = 1'b0;

        // Capture/unload with n514 tied high.
        run(29'h0000_0003, 0, 1'b0);
        // Start pulses while busy and in DONE; n514 toggling with 0 at capture.
        run(29'($urandom), 1, 1'b1);
        // All-ones load.
        run(29'h1FFF_FFFF, 2, 1'b0);
        // Random runs.
        for (int r = 0; r < 4; r++)
            run(29'($urandom), int'($urandom_range(2)), r[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
